// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped read-only instruction cache, 0-cycle hits, word-by-word line refill on miss.
// Valid bits and FSM state reset asynchronously; tag and data arrays are left uninitialised.
module icache_ctrl #(
   parameter int bit_size   = 18,
   parameter int data_size  = 32,
   parameter int index_bits = 6
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [bit_size-1:0]  pc,
   input  logic                 flush,
   output logic [data_size-1:0] instr,
   output logic                 stall,
   output logic                 mem_read,
   output logic [bit_size-1:0]  mem_addr,
   input  logic                 mem_ready,
   input  logic [data_size-1:0] mem_rdata
);
   localparam int tag_bits = bit_size - index_bits - 4;
   localparam int lines    = 1 << index_bits;

   typedef enum logic {LOOKUP, REFILL} state_t;

   state_t                state_q;
   logic [lines-1:0]      valid_q;
   logic [tag_bits-1:0]   tag_q [lines];
   logic [data_size-1:0]  data_q [lines*4];
   logic [1:0]            beat_q;
   logic [bit_size-1:0]   base_q;
   logic                  flushed_q;
   logic                  mem_read_q;
   logic [bit_size-1:0]   mem_addr_q;

   logic [index_bits-1:0] idx, fill_idx;
   logic [tag_bits-1:0]   tag;
   logic                  hit, lookup_hit, last_beat;
   logic                  unused_ok;

   assign idx        = pc[index_bits+3:4];
   assign tag        = pc[bit_size-1:index_bits+4];
   assign fill_idx   = base_q[index_bits+3:4];
   assign hit        = valid_q[idx] && (tag_q[idx] == tag);
   assign lookup_hit = rst && (state_q == LOOKUP) && hit;
   assign last_beat  = (state_q == REFILL) && mem_ready && (beat_q == 2'd3);
   assign unused_ok  = ^pc[1:0];

   // Outputs are quiet while reset is held, so stall is gated by rst too.
   assign stall    = rst && !lookup_hit;
   assign instr    = lookup_hit ? data_q[{idx, pc[3:2]}] : '0;
   assign mem_read = mem_read_q;
   assign mem_addr = mem_addr_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= LOOKUP;
         valid_q    <= '0;
         beat_q     <= '0;
         base_q     <= '0;
         flushed_q  <= 1'b0;
         mem_read_q <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         if (state_q == LOOKUP) begin
            if (!hit) begin
               state_q    <= REFILL;
               base_q     <= {pc[bit_size-1:4], 4'b0};
               mem_addr_q <= {pc[bit_size-1:4], 4'b0};
               beat_q     <= '0;
               flushed_q  <= 1'b0;
               mem_read_q <= 1'b1;
            end
         end else begin
            if (flush) flushed_q <= 1'b1;
            if (mem_ready) begin
               beat_q     <= beat_q + 2'd1;
               mem_addr_q <= base_q | {{(bit_size-4){1'b0}}, beat_q + 2'd1, 2'b00};
               if (beat_q == 2'd3) begin
                  state_q    <= LOOKUP;
                  mem_read_q <= 1'b0;
               end
            end
         end
         // A flush seen anywhere in the refill leaves the freshly filled line invalid.
         if (flush) valid_q <= '0;
         else if (last_beat) valid_q[fill_idx] <= ~flushed_q;
      end
   end

   always_ff @(posedge clk) begin
      if ((state_q == REFILL) && mem_ready) data_q[{fill_idx, beat_q}] <= mem_rdata;
      if (last_beat) tag_q[fill_idx] <= base_q[bit_size-1:index_bits+4];
   end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed bench for icache_ctrl covering cold miss, hits, eviction, waits, flush and reset.
module tb_icache_ctrl;
   logic        clk = 1'b0;
   logic        rst, flush, mem_ready, stall, mem_read;
   logic [17:0] pc, mem_addr;
   logic [31:0] instr, mem_rdata;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   icache_ctrl dut (
      .clk(clk), .rst(rst), .pc(pc), .flush(flush), .instr(instr), .stall(stall),
      .mem_read(mem_read), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   function automatic logic [31:0] word_of(input logic [17:0] a);
      return 32'h5A00_0000 | {14'h0, a};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic fetch(input logic [17:0] a);
      @(negedge clk);
      pc = a;
      #1;
   endtask

   task automatic expect_hit(input logic [17:0] a);
      fetch(a);
      chk("hit_stall", stall, 0);
      chk("hit_instr", instr, word_of(a));
      chk("hit_mem_read", mem_read, 0);
   endtask

   // Called in the miss cycle; ends one cycle after the final mem_ready.
   task automatic refill(input logic [17:0] base, input int waits, input int fbeat);
      int stalls;
      stalls = int'(stall);
      chk("miss_stall", stall, 1);
      chk("miss_mem_read", mem_read, 0);
      for (int b = 0; b < 4; b++) begin
         for (int w = 0; w <= waits; w++) begin
            @(negedge clk);
            mem_ready = (w == waits);
            flush = (b == fbeat) && (w == 0);
            mem_rdata = mem_ready ? word_of(base + 18'(4*b)) : 32'hDEAD_BEEF;
            #1;
            if (stall) stalls++;
            chk("refill_mem_read", mem_read, 1);
            chk("refill_addr", mem_addr, base + 18'(4*b));
         end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      flush = 1'b0;
      mem_rdata = '0;
      #1;
      chk("stall_total", stalls, 1 + 4*(waits + 1));
   endtask

   initial begin
      rst = 1'b0; pc = 18'h00010; flush = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_instr", instr, 0);
      chk("rst_mem_read", mem_read, 0);
      chk("rst_mem_addr", mem_addr, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      refill(18'h00010, 0, -1);
      chk("cold_stall", stall, 0);
      chk("cold_instr", instr, word_of(18'h00010));
      expect_hit(18'h00014);
      expect_hit(18'h00018);
      expect_hit(18'h0001C);
      // mem_ready must be ignored while looking up
      @(negedge clk);
      mem_ready = 1'b1;
      #1;
      chk("lookup_ready_stall", stall, 0);
      chk("lookup_ready_instr", instr, word_of(18'h0001C));
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("lookup_ready_mem_read", mem_read, 0);

      fetch(18'h00410);
      refill(18'h00410, 0, -1);
      expect_hit(18'h00410);
      expect_hit(18'h0041C);
      fetch(18'h00010);
      refill(18'h00010, 0, -1);
      expect_hit(18'h00010);

      fetch(18'h00820);
      refill(18'h00820, 3, -1);
      expect_hit(18'h00820);
      expect_hit(18'h0082C);

      expect_hit(18'h00018);
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("flush_cycle_stall", stall, 0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      refill(18'h00010, 0, -1);
      expect_hit(18'h00018);
      fetch(18'h00824);
      refill(18'h00820, 0, -1);
      expect_hit(18'h00824);

      fetch(18'h00030);
      refill(18'h00030, 0, 1);
      chk("flushed_refill_miss", stall, 1);
      refill(18'h00030, 0, -1);
      expect_hit(18'h00030);

      fetch(18'h00044);
      chk("rr_miss", stall, 1);
      for (int b = 0; b < 2; b++) begin
         @(negedge clk);
         mem_ready = 1'b1;
         mem_rdata = word_of(18'h00040 + 18'(4*b));
         #1;
      end
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("rr_beat2_addr", mem_addr, 18'h00048);
      chk("rr_beat2_mem_read", mem_read, 1);
      rst = 1'b0;
      #1;
      chk("rr_mem_read", mem_read, 0);
      chk("rr_stall", stall, 0);
      chk("rr_instr", instr, 0);
      chk("rr_mem_addr", mem_addr, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      refill(18'h00040, 0, -1);
      expect_hit(18'h00044);
      expect_hit(18'h0004C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Direct-mapped, read-only instruction cache controller sitting between the program counter and the instruction memory. It takes the current fetch address, returns the instruction word on a hit in the same cycle, and on a miss raises `stall` and refills the whole line from memory word by word. The PC stage uses the inverse of `stall` as its write enable, so the fetch address stays constant for the whole refill.

## Interface
- `bit_size`, 18: fetch/memory byte-address width.
- `data_size`, 32: instruction word width.
- `index_bits`, 6: line index width (2^6 = 64 lines). Line = 4 words = 16 bytes; tag width = `bit_size` − `index_bits` − 4.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `pc` in `bit_size`: fetch byte address; bits [1:0] ignored.
- `flush` in 1: invalidate all lines.
- `instr` out `data_size`: fetched instruction; valid when `stall`=0.
- `stall` out 1: 1 = instruction not available; hold PC.
- `mem_read` out 1: word read request to memory.
- `mem_addr` out `bit_size`: word-aligned byte address of the requested word.
- `mem_ready` in 1: one-cycle pulse; `mem_rdata` is valid in that cycle.
- `mem_rdata` in `data_size`: memory read data.

## Operation
- Address split: offset [3:0] (word select [3:2]), index [`index_bits`+3:4], tag = remaining upper bits.
- Storage: per line, one valid bit, one tag, and 4 data words.
- States:
  - LOOKUP (reset state): `hit` = valid[index] AND tag match. `instr` = data[index][pc[3:2]] and `stall`=0 on a hit. On a miss, `instr`=0 and `stall`=1; capture line base {tag,index,4'b0}, clear the beat counter, and go to REFILL.
- REFILL:
  - Drive `mem_read`=1 and `mem_addr` = line base + 4×beat. `stall`=1 throughout.
  - On `mem_ready`, write `mem_rdata` into word[beat] and increment beat.
  - On the beat-3 `mem_ready`, write the tag, set valid (subject to the flush rule below), and return to LOOKUP.
  - `mem_read` drops in the cycle after the final `mem_ready`.
- `mem_ready` is ignored in LOOKUP. `pc` is not re-sampled during REFILL; the captured line base is used.
- Flush:
  - Clears all valid bits at the next edge, in any state.
  - If `flush` is asserted at any point during a REFILL, that refill still completes all 4 beats, but the line is written with valid=0. The next LOOKUP then misses and refills again.
  - A flush in LOOKUP produces a miss in the following cycle.
- Replacement: a refill overwrites the indexed line unconditionally (direct-mapped, no write path).

## Timing
- Reset (`rst`=0) behaviour, asynchronous:
  - state = LOOKUP, all valid bits = 0, beat = 0, `mem_read`=0, `mem_addr`=0.
  - While reset is held, `stall`=0 and `instr`=0.
  - Data and tag arrays are not reset.
- Reset during REFILL aborts the refill immediately. `mem_read` drops asynchronously, and the line is not validated.
- Hit latency is 0 cycles: `instr` and `stall` are combinational from `pc` and the arrays.
- Miss: `stall` rises in the same cycle the miss is seen.
  - First `mem_read` is high from the next edge.
  - With zero-wait memory (`mem_ready` in every REFILL cycle), REFILL lasts 4 cycles, the hit is in the 5th cycle after the miss, and total stall = 5 cycles.
  - Each memory wait cycle adds 1 stall cycle.
- `mem_addr` is stable while `mem_read`=1 and only advances at the edge following `mem_ready`.

## Test plan
- Cold miss, zero-wait memory. Release reset, `pc`=0x00010.
  - Required: `stall`=1; `mem_addr` sequence 0x00010, 0x00014, 0x00018, 0x0001C.
  - Then `stall`=0 and `instr` = the word returned for 0x00010, 5 cycles after the miss.
- Same-line hits. After the refill above, step `pc` through 0x00014, 0x00018, 0x0001C.
  - Required: `stall`=0 every cycle, each `instr` matches the refill data, and `mem_read` stays 0.
- Conflict eviction. Refill 0x00010, then `pc`=0x00410 (same index 1, different tag).
  - Required: miss with refill from 0x00410–0x0041C.
  - Returning to 0x00010 then misses again.
- Wait states. Hold `mem_ready` low 3 cycles before each beat.
  - Required: `mem_addr` is held until its `mem_ready`; total stall = 5 + 12 = 17 cycles; correct `instr` afterwards.
- Flush.
  - Pulse `flush` in LOOKUP after a valid line: the next access to that line misses.
  - Pulse `flush` during beat 1 of a refill: all 4 beats complete, `stall` stays 1, and a second refill of the same line follows.
- Reset mid-refill. Assert `rst`=0 at beat 2.
  - Required: `mem_read`=0 immediately and `stall`=0 while in reset.
  - After release, the same `pc` misses and restarts from beat 0 at the line base.
